// File: rtl/par_uart_tx.sv
// Debug console transmitter: strobe rising edges queue the parallel port byte
// into a small FIFO, and queued bytes leave on uart_tx as 8N1 frames, LSB first.
module par_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    par_output_port,
    input  logic                          par_output_signal,
    input  logic                          overflow_clr,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [15:0]   LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state, w_nState;
    logic [15:0]   r_bitCnt, w_nBitCnt;
    logic [2:0]    r_bitIdx, w_nBitIdx;
    logic [7:0]    r_shift, w_nShift;
    logic          r_tx, w_nTx;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wrPtr, r_rdPtr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_sigQ;

    logic          w_push, w_pop, w_full, w_accept, w_ovfSet, w_notEmpty;

    assign w_push     = par_output_signal & ~r_sigQ;
    assign w_full     = (r_count == DEPTH_C);
    assign w_notEmpty = (r_count != '0);
    // A full FIFO still takes a byte when the same edge pops one.
    assign w_accept   = w_push & (~w_full | w_pop);
    assign w_ovfSet   = w_push & w_full & ~w_pop;

    assign uart_tx    = r_tx;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign busy       = (r_state != IDLE) | w_notEmpty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_bitCnt <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_nState;
            r_bitCnt <= w_nBitCnt;
            r_bitIdx <= w_nBitIdx;
            r_shift  <= w_nShift;
            r_tx     <= w_nTx;
        end
    end

    always_comb begin
        w_nState  = r_state;
        w_nBitCnt = r_bitCnt;
        w_nBitIdx = r_bitIdx;
        w_nShift  = r_shift;
        w_nTx     = r_tx;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: begin
                w_nTx = 1'b1;
                if (w_notEmpty) begin
                    w_pop     = 1'b1;
                    w_nShift  = r_mem[r_rdPtr];
                    w_nTx     = 1'b0;
                    w_nBitCnt = '0;
                    w_nState  = START;
                end
            end
            START: begin
                if (r_bitCnt == LAST_CNT) begin
                    w_nBitCnt = '0;
                    w_nBitIdx = '0;
                    w_nTx     = r_shift[0];
                    w_nState  = DATA;
                end else begin
                    w_nBitCnt = r_bitCnt + 16'd1;
                end
            end
            DATA: begin
                if (r_bitCnt == LAST_CNT) begin
                    w_nBitCnt = '0;
                    if (r_bitIdx == 3'd7) begin
                        w_nTx    = 1'b1;
                        w_nState = STOP;
                    end else begin
                        w_nShift  = r_shift >> 1;
                        w_nTx     = r_shift[1];
                        w_nBitIdx = r_bitIdx + 3'd1;
                    end
                end else begin
                    w_nBitCnt = r_bitCnt + 16'd1;
                end
            end
            STOP: begin
                if (r_bitCnt == LAST_CNT) begin
                    w_nBitCnt = '0;
                    // Chain straight into the next start bit when more bytes wait.
                    if (w_notEmpty) begin
                        w_pop    = 1'b1;
                        w_nShift = r_mem[r_rdPtr];
                        w_nTx    = 1'b0;
                        w_nState = START;
                    end else begin
                        w_nTx    = 1'b1;
                        w_nState = IDLE;
                    end
                end else begin
                    w_nBitCnt = r_bitCnt + 16'd1;
                end
            end
            default: begin
                w_nState = IDLE;
                w_nTx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sigQ     <= 1'b1;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_sigQ <= par_output_signal;
            if (w_accept) r_wrPtr <= r_wrPtr + PTR_ONE;
            if (w_pop)    r_rdPtr <= r_rdPtr + PTR_ONE;
            if (w_accept && !w_pop)
                r_count <= r_count + CNT_ONE;
            else if (!w_accept && w_pop)
                r_count <= r_count - CNT_ONE;
            if (w_ovfSet)
                r_overflow <= 1'b1;
            else if (overflow_clr)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wrPtr] <= par_output_port;
    end

endmodule

// File: tb/tb_par_uart_tx.sv
// Directed bench for par_uart_tx: frame shape, back-to-back chaining, overflow,
// level strobe, reset mid-frame and power-up-high strobe, at 4 clocks per bit.
module tb_par_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] port;
    logic       sig;
    logic       clr;
    logic       uartTx;
    logic       busy;
    logic [2:0] fifoCount;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int waitA;
    int waitB;

    always #5 clk = ~clk;

    par_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .par_output_port   (port),
        .par_output_signal (sig),
        .overflow_clr      (clr),
        .uart_tx           (uartTx),
        .busy              (busy),
        .fifo_count        (fifoCount),
        .overflow          (overflow)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One strobe pulse (high one cycle, low one cycle) with FIFO state checked after the push edge.
    task automatic applyStimulus(input logic [7:0] data, input int expCount, input logic expOvf);
        port = data;
        sig  = 1'b1;
        @(negedge clk);
        sig = 1'b0;
        checkOutput("fifoCount", fifoCount, expCount);
        checkOutput("overflow", overflow, expOvf);
        @(negedge clk);
    endtask

    // Called on a negedge; waits for the start bit, then checks all 10*CPB samples of the frame.
    task automatic recvFrame(input logic [7:0] data, input int timeout, output int waited);
        logic [9:0] frame;
        logic [7:0] got;
        int holdErrs;
        frame    = {1'b1, data, 1'b0};
        got      = '0;
        holdErrs = 0;
        waited   = 0;
        while (uartTx !== 1'b0 && waited < timeout) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("frameStart", 32'(waited < timeout), 1);
        for (int n = 0; n < 10 * CPB; n++) begin
            if (uartTx !== frame[n / CPB]) holdErrs++;
            if ((n % CPB) == CPB / 2 && (n / CPB) >= 1 && (n / CPB) <= 8)
                got[(n / CPB) - 1] = uartTx;
            if (n == 10 * CPB - 1) checkOutput("busyLastCycle", busy, 1);
            @(negedge clk);
        end
        checkOutput("frameBits", holdErrs, 0);
        checkOutput("frameByte", got, data);
    endtask

    task automatic noFrame(input int cycles);
        int lows;
        lows = 0;
        repeat (cycles) begin
            if (uartTx !== 1'b1) lows++;
            @(negedge clk);
        end
        checkOutput("lineIdle", lows, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        sig  = 1'b0;
        port = 8'h00;
        clr  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstTx", uartTx, 1);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstCount", fifoCount, 0);
        checkOutput("rstOverflow", overflow, 0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Single byte 0xA5: line falls one edge after the push edge, busy drops after 40 cycles.
        port = 8'hA5;
        sig  = 1'b1;
        @(negedge clk);
        sig = 1'b0;
        checkOutput("singleCount", fifoCount, 1);
        checkOutput("singleTxIdle", uartTx, 1);
        checkOutput("singleBusy", busy, 1);
        recvFrame(8'hA5, 20, waitA);
        checkOutput("singleLatency", waitA, 1);
        checkOutput("singleBusyEnd", busy, 0);
        checkOutput("singleTxEnd", uartTx, 1);

        // Back-to-back frames must chain with no idle gap.
        fork
            begin
                recvFrame(8'h00, 20, waitA);
                recvFrame(8'hFF, 5, waitA);
                checkOutput("b2bGap1", waitA, 0);
                recvFrame(8'h3C, 5, waitA);
                checkOutput("b2bGap2", waitA, 0);
            end
            begin
                applyStimulus(8'h00, 1, 1'b0);
                applyStimulus(8'hFF, 1, 1'b0);
                applyStimulus(8'h3C, 2, 1'b0);
            end
        join
        checkOutput("b2bBusy", busy, 0);
        checkOutput("b2bCount", fifoCount, 0);

        // Six pushes during the first frame: the sixth finds the FIFO full and is dropped.
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    recvFrame(8'(i), (i == 1) ? 20 : 5, waitA);
                    if (i > 1) checkOutput("ovfGap", waitA, 0);
                end
                noFrame(30);
            end
            begin
                for (int i = 0; i < 6; i++)
                    applyStimulus(8'(i + 1), (i == 0) ? 1 : ((i > 4) ? 4 : i), i == 5);
            end
        join
        checkOutput("ovfSticky", overflow, 1);
        checkOutput("ovfBusy", busy, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checkOutput("ovfCleared", overflow, 0);

        // Push into a full FIFO on the exact edge the stop bit pops: accepted, no overflow.
        fork
            begin
                recvFrame(8'h81, 20, waitB);
                for (int i = 1; i < 6; i++) begin
                    recvFrame(8'(8'h81 + i), 5, waitB);
                    checkOutput("fullPopGap", waitB, 0);
                end
            end
            begin
                for (int i = 0; i < 5; i++)
                    applyStimulus(8'(8'h81 + i), (i == 0) ? 1 : i, 1'b0);
                repeat (31) @(negedge clk);
                port = 8'h86;
                sig  = 1'b1;
                @(negedge clk);
                sig = 1'b0;
                checkOutput("fullPopCount", fifoCount, 4);
                checkOutput("fullPopOverflow", overflow, 0);
            end
        join
        checkOutput("fullPopBusy", busy, 0);

        // Level strobe held 100 cycles while the port changes: one frame carrying 0x11.
        fork
            begin
                recvFrame(8'h11, 20, waitA);
                noFrame(80);
            end
            begin
                port = 8'h11;
                sig  = 1'b1;
                repeat (5) @(negedge clk);
                port = 8'h22;
                repeat (95) @(negedge clk);
                sig = 1'b0;
            end
        join
        checkOutput("levelBusy", busy, 0);

        // Reset during data bit 3 with two bytes queued.
        applyStimulus(8'h41, 1, 1'b0);
        applyStimulus(8'h42, 1, 1'b0);
        applyStimulus(8'h43, 2, 1'b0);
        repeat (12) @(negedge clk);
        checkOutput("midBit3", uartTx, 0);
        checkOutput("midCount", fifoCount, 2);
        rst = 1'b1;
        #1;
        checkOutput("midRstTx", uartTx, 1);
        checkOutput("midRstCount", fifoCount, 0);
        checkOutput("midRstBusy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        noFrame(60);
        checkOutput("midAfterBusy", busy, 0);

        // Strobe high through reset release must not capture; a later 0->1 does.
        rst  = 1'b1;
        sig  = 1'b1;
        port = 8'h55;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        noFrame(20);
        checkOutput("pwrBusy", busy, 0);
        checkOutput("pwrCount", fifoCount, 0);
        sig = 1'b0;
        @(negedge clk);
        port = 8'h7E;
        sig  = 1'b1;
        recvFrame(8'h7E, 20, waitA);
        checkOutput("pwrLatency", waitA, 2);
        sig = 1'b0;
        noFrame(20);
        checkOutput("pwrEndBusy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/par_uart_tx.md
Name: par_uart_tx

Overview:
Downstream consumer of the memory-mapper's parallel output port. It watches the 8-bit port data and the 1-bit strobe signal that software drives through MMIO writes. Each rising edge of the strobe queues the current port byte into a small FIFO. Queued bytes are serialised on a single UART TX line as 8N1, LSB first, giving the CPU a debug/console output channel without polling.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
FIFO_DEPTH, 4, byte FIFO entries; power of two, at least 2.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
par_output_port  input  8  byte to transmit; driven by the mem block port register.
par_output_signal  input  1  strobe from the mem block; each rising edge enqueues par_output_port.
overflow_clr  input  1  synchronous clear of the overflow flag.
uart_tx  output  1  serial line; idles high; registered.
busy  output  1  high when a frame is in flight or the FIFO is non-empty.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the byte being shifted.
overflow  output  1  sticky flag: a strobe was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous): uart_tx=1, state=IDLE, FIFO empty, fifo_count=0, overflow=0, busy=0, strobe history sig_q=1.
- Because sig_q resets to 1, the strobe must be seen low before a rising edge counts. A strobe input that powers up high therefore causes no capture.
- Edge detect: push = par_output_signal & ~sig_q, evaluated at each clk edge; sig_q <= par_output_signal every cycle.
- At the push edge, par_output_port is written into the FIFO. Software writes the data before raising the strobe; a level held high produces only one push.
- Pop: the FIFO pops only when a new frame is loaded. This happens in IDLE with a non-empty FIFO, or at the final cycle of STOP with a non-empty FIFO.
- FIFO, push in the same cycle as pop: both take effect, so count is unchanged.
  - This holds even when the FIFO is full: the push is accepted and overflow is not set.
- FIFO full with push and no pop: the byte is dropped, overflow <= 1, and count is unchanged.
- If overflow_clr and an overflow event occur in the same cycle, set wins. Otherwise overflow_clr clears the flag at the next edge.
- FSM states: IDLE, START, DATA, STOP. A bit counter counts 0..CLKS_PER_BIT-1 and a bit index counts 0..7.
  - IDLE: uart_tx=1. If the FIFO is non-empty: pop into the shift register, uart_tx<=0, go to START, bit counter=0.
  - START: hold uart_tx=0 for CLKS_PER_BIT cycles. Then uart_tx<=shift[0] and go to DATA with bit index 0.
  - DATA: hold each bit for CLKS_PER_BIT cycles and shift right. After bit 7, uart_tx<=1 and go to STOP.
  - STOP: hold uart_tx=1 for CLKS_PER_BIT cycles. At the last cycle, if the FIFO is non-empty, pop, uart_tx<=0 and go to START with no idle gap. Otherwise go to IDLE.
- Latency: with the strobe sampled high at edge E (push at E), IDLE pops at E+1 and uart_tx falls after E+1. The frame lasts exactly 10*CLKS_PER_BIT cycles, from uart_tx falling to the end of the stop bit.
- busy = (state != IDLE) | (fifo_count != 0), combinational.
- Changes to par_output_port after its push have no effect on queued or in-flight data.
- Reset mid-frame: the line returns high immediately and the queued bytes are lost.
- Counter arithmetic: the FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. fifo_count is computed from occupancy and never exceeds FIFO_DEPTH.

Test Plan:
- Single byte, CLKS_PER_BIT=4: port=0xA5, strobe 0→1 at edge E → uart_tx falls after E+1. The line then carries 0,1,0,1,0,0,1,0,1,1 for 4 cycles each, and busy drops after 40 cycles.
- Back-to-back: push 0x00, 0xFF, 0x3C on consecutive strobe pulses → three contiguous frames with no idle cycle between the stop bit and the next start bit; fifo_count steps 1,2 and then drains to 0.
- Overflow, FIFO_DEPTH=4: push six bytes 0x01..0x06 while the first frame is in flight → 0x01..0x05 are transmitted and 0x06 is dropped; overflow=1 until overflow_clr is pulsed, then 0.
- Level strobe: hold par_output_signal high for 100 cycles while changing the port 0x11→0x22 → exactly one frame, carrying 0x11.
- Reset mid-frame: assert rst during DATA bit 3 with 2 bytes queued → uart_tx=1 immediately, fifo_count=0, busy=0, and no frame follows deassertion.
- Power-up-high strobe: par_output_signal=1 through reset release → no frame. A subsequent 0→1 transition with port 0x7E produces one frame carrying 0x7E.
